// File: rtl/junction_controller_pkg.sv
// Shared types and lamp encodings for the two-road junction controller.
// Lamp vectors are ordered {red, amber, green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        RA     = 3'd1,
        GRN    = 3'd2,
        AMB    = 3'd3,
        WALK   = 3'd4
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [2:0] RED       = 3'b100;
    localparam logic [2:0] RED_AMBER = 3'b110;
    localparam logic [2:0] GREEN     = 3'b001;
    localparam logic [2:0] AMBER     = 3'b010;

    // A head that does not own the current phase always shows red.
    function automatic logic [2:0] head_lamp(input state_t st, input logic owns_phase);
        logic [2:0] lamp;
        lamp = RED;
        if (owns_phase) begin
            case (st)
                RA:      lamp = RED_AMBER;
                GRN:     lamp = GREEN;
                AMB:     lamp = AMBER;
                default: lamp = RED;
            endcase
        end
        return lamp;
    endfunction

endpackage

// File: rtl/junction_controller_if.sv
// Detector inputs and lamp outputs of the junction controller.
// master = controller side, slave = junction/roadside side.
interface junction_controller_if;

    logic ew_car;
    logic ped_req;
    logic ns_red;
    logic ns_amber;
    logic ns_green;
    logic ew_red;
    logic ew_amber;
    logic ew_green;
    logic walk;
    logic ped_waiting;

    modport master (
        input  ew_car,
        input  ped_req,
        output ns_red,
        output ns_amber,
        output ns_green,
        output ew_red,
        output ew_amber,
        output ew_green,
        output walk,
        output ped_waiting
    );

    modport slave (
        output ew_car,
        output ped_req,
        input  ns_red,
        input  ns_amber,
        input  ns_green,
        input  ew_red,
        input  ew_amber,
        input  ew_green,
        input  walk,
        input  ped_waiting
    );

endinterface

// File: rtl/junction_controller_dwell_timer.sv
// Dwell counter: cleared on state entry, counts up, flags done at DUR-1.
// With sat_en the count parks at DUR-1 instead of advancing.
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sat_en,
    input  logic [CNT_W-1:0] dur_m1,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == dur_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!(sat_en && done)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/junction_controller.sv
// Two-road junction sequencer: NS/EW heads, all-red clearance, side-road
// detection and a latched pedestrian request served from an all-red phase.
module junction_controller
    import traffic_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int GREEN_CYCLES     = 4,
    parameter int AMBER_CYCLES     = 2,
    parameter int RED_AMBER_CYCLES = 2,
    parameter int ALLRED_CYCLES    = 1,
    parameter int WALK_CYCLES      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    junction_controller_if.master  bus
);

    state_t           state;
    state_t           state_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             ped_pending;
    logic             ped_nxt;
    logic             enter_walk;
    logic             clear;
    logic             sat_en;
    logic             done;
    logic [CNT_W-1:0] dur_m1;
    logic [2:0]       ns_lamp;
    logic [2:0]       ew_lamp;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .sat_en (sat_en),
        .dur_m1 (dur_m1),
        .done   (done)
    );

    always_comb begin
        dur_m1 = CNT_W'(ALLRED_CYCLES - 1);
        case (state)
            ALLRED:  dur_m1 = CNT_W'(ALLRED_CYCLES - 1);
            RA:      dur_m1 = CNT_W'(RED_AMBER_CYCLES - 1);
            GRN:     dur_m1 = CNT_W'(GREEN_CYCLES - 1);
            AMB:     dur_m1 = CNT_W'(AMBER_CYCLES - 1);
            WALK:    dur_m1 = CNT_W'(WALK_CYCLES - 1);
            default: dur_m1 = CNT_W'(ALLRED_CYCLES - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ALLRED;
            dir         <= DIR_NS;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            ped_pending <= ped_nxt;
        end
    end

    // Main-road green is the rest phase: it only yields once minimum green
    // has elapsed and somebody is actually waiting.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        case (state)
            ALLRED: begin
                if (done) state_nxt = ped_pending ? WALK : RA;
            end
            WALK: begin
                if (done) state_nxt = RA;
            end
            RA: begin
                if (done) state_nxt = GRN;
            end
            GRN: begin
                if (dir == DIR_EW) begin
                    if (done) state_nxt = AMB;
                end else if (done && (bus.ew_car || ped_pending)) begin
                    state_nxt = AMB;
                end
            end
            AMB: begin
                if (done) begin
                    state_nxt = ALLRED;
                    dir_nxt   = ~dir;
                end
            end
            default: begin
                state_nxt = ALLRED;
                dir_nxt   = DIR_NS;
            end
        endcase
    end

    assign clear  = (state_nxt != state);
    assign sat_en = (state == GRN) && (dir == DIR_NS);

    // A request seen while walking, or on the edge that starts the walk,
    // is already being served and must not re-latch.
    assign enter_walk = (state_nxt == WALK) && (state != WALK);

    always_comb begin
        ped_nxt = ped_pending;
        if (enter_walk) begin
            ped_nxt = 1'b0;
        end else if (bus.ped_req && (state != WALK) && (state_nxt != WALK)) begin
            ped_nxt = 1'b1;
        end
    end

    assign ns_lamp = head_lamp(state, dir == DIR_NS);
    assign ew_lamp = head_lamp(state, dir == DIR_EW);

    assign {bus.ns_red, bus.ns_amber, bus.ns_green} = ns_lamp;
    assign {bus.ew_red, bus.ew_amber, bus.ew_green} = ew_lamp;
    assign bus.walk        = (state == WALK);
    assign bus.ped_waiting = ped_pending;

endmodule

// File: tb/tb_junction_controller.sv
// Randomised bench for junction_controller against a lamp-schedule model:
// expected per-cycle lamp states are queued as phase segments ahead of time.
module tb_junction_controller;
    import traffic_pkg::*;

    localparam int G   = 4;
    localparam int A   = 2;
    localparam int RAC = 2;
    localparam int AR  = 1;
    localparam int W   = 3;

    localparam logic [1:0] T_NONE   = 2'd0;
    localparam logic [1:0] T_DECIDE = 2'd1;
    localparam logic [1:0] T_HOLD   = 2'd2;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic [1:0] tag;
    } item_t;

    logic  clk;
    logic  rst_n;
    int    n_checks;
    int    n_errors;
    item_t plan[$];
    logic  m_pend;
    logic  m_dir;

    junction_controller_if jif();

    junction_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (jif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_n(input logic [2:0] ns, input logic [2:0] ew, input logic wk,
                          input int n, input logic [1:0] last_tag);
        for (int i = 0; i < n; i++) begin
            item_t it;
            it.ns  = ns;
            it.ew  = ew;
            it.wk  = wk;
            it.tag = (i == n - 1) ? last_tag : T_NONE;
            plan.push_back(it);
        end
    endtask

    // One green phase for road d; NS green ends in an open-ended hold slot.
    task automatic push_phase(input logic d);
        if (d == DIR_NS) begin
            push_n(RED_AMBER, RED, 1'b0, RAC, T_NONE);
            push_n(GREEN, RED, 1'b0, G, T_HOLD);
        end else begin
            push_n(RED, RED_AMBER, 1'b0, RAC, T_NONE);
            push_n(RED, GREEN, 1'b0, G, T_NONE);
            push_n(RED, AMBER, 1'b0, A, T_NONE);
            push_n(RED, RED, 1'b0, AR, T_DECIDE);
            m_dir = DIR_NS;
        end
    endtask

    task automatic model_reset();
        plan.delete();
        m_pend = 1'b0;
        m_dir  = DIR_NS;
        push_n(RED, RED, 1'b0, AR, T_DECIDE);
    endtask

    task automatic model_edge(input logic car, input logic req);
        item_t old;
        logic  was_walk;
        old      = plan[0];
        was_walk = old.wk;
        if (!(old.tag == T_HOLD && !(car || m_pend))) begin
            void'(plan.pop_front());
            if (old.tag == T_HOLD) begin
                push_n(AMBER, RED, 1'b0, A, T_NONE);
                push_n(RED, RED, 1'b0, AR, T_DECIDE);
                m_dir = DIR_EW;
            end else if (old.tag == T_DECIDE) begin
                if (m_pend) push_n(RED, RED, 1'b1, W, T_NONE);
                push_phase(m_dir);
            end
        end
        if (plan[0].wk && !was_walk) m_pend = 1'b0;
        else if (req && !was_walk && !plan[0].wk) m_pend = 1'b1;
    endtask

    task automatic compare_outputs();
        logic [2:0] ns;
        logic [2:0] ew;
        ns = {jif.ns_red, jif.ns_amber, jif.ns_green};
        ew = {jif.ew_red, jif.ew_amber, jif.ew_green};
        check_eq("ns_head", 32'(ns), 32'(plan[0].ns));
        check_eq("ew_head", 32'(ew), 32'(plan[0].ew));
        check_eq("walk", 32'(jif.walk), 32'(plan[0].wk));
        check_eq("ped_waiting", 32'(jif.ped_waiting), 32'(m_pend));
        check_eq("one_head_nonred", 32'((ns != RED) && (ew != RED)), 32'd0);
        check_eq("walk_needs_red", 32'(jif.walk && ((ns != RED) || (ew != RED))), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(jif.ew_car, jif.ped_req);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic wait_ew_green(input int budget);
        int n;
        n = 0;
        while (plan[0].ew != GREEN && n < budget) begin
            cycle();
            n++;
        end
        check_eq("wait_ew_green_timeout", 32'(plan[0].ew != GREEN), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        jif.ew_car  = 1'b0;
        jif.ped_req = 1'b0;
        rst_n       = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;
        #1;
        compare_outputs();

        // idle: NS green holds indefinitely
        repeat (25) cycle();
        check_eq("ns_rest_green", 32'({jif.ns_red, jif.ns_amber, jif.ns_green}), 32'(GREEN));

        // side-road demand: steady 18-cycle rotation
        jif.ew_car = 1'b1;
        repeat (40) cycle();

        // pedestrian pulse during EW green
        wait_ew_green(40);
        jif.ped_req = 1'b1;
        cycle();
        jif.ped_req = 1'b0;
        check_eq("ped_latched", 32'(jif.ped_waiting), 32'd1);
        jif.ew_car = 1'b0;
        repeat (30) cycle();

        // request held through the walk must not re-latch
        jif.ped_req = 1'b1;
        cycle();
        jif.ped_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            jif.ped_req = plan[0].wk;
            cycle();
        end
        jif.ped_req = 1'b0;
        repeat (10) cycle();
        check_eq("ped_no_relatch", 32'(jif.ped_waiting), 32'd0);

        // asynchronous reset mid-cycle during EW green
        jif.ew_car = 1'b1;
        wait_ew_green(40);
        jif.ped_req = 1'b1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ns", 32'({jif.ns_red, jif.ns_amber, jif.ns_green}), 32'(RED));
        check_eq("rst_ew", 32'({jif.ew_red, jif.ew_amber, jif.ew_green}), 32'(RED));
        check_eq("rst_walk", 32'(jif.walk), 32'd0);
        check_eq("rst_ped_waiting", 32'(jif.ped_waiting), 32'd0);
        @(negedge clk);
        jif.ped_req = 1'b0;
        jif.ew_car  = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1;
        compare_outputs();
        repeat (25) cycle();

        // random demand
        for (int i = 0; i < 400; i++) begin
            jif.ew_car  = ($urandom_range(0, 3) == 0);
            jif.ped_req = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
